// File: rtl/shift_ctrl.sv
// Shift datapath sequencer: drives source/amount mux selects and the
// shifter command through load, shift and writeback for one operation.
module shift_ctrl #(
    parameter int unsigned LUI_AMT = 16,
    parameter int unsigned STATE_W = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    output logic [1:0] shift_src,
    output logic [1:0] amt_src,
    output logic [2:0] shift_cmd,
    output logic       busy,
    output logic       done,
    output logic       res_we,
    output logic       err
);

    // The amount mux constant must be a legal 5-bit shift amount and
    // the state register must be able to hold all five states.
    if (LUI_AMT == 0 || LUI_AMT > 31) begin : g_bad_lui_amt
        $error("shift_ctrl: LUI_AMT must be in 1..31");
    end
    if (STATE_W < 3) begin : g_bad_state_w
        $error("shift_ctrl: STATE_W must be at least 3");
    end

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = STATE_W'(0),
        S_LOAD  = STATE_W'(1),
        S_SHIFT = STATE_W'(2),
        S_WB    = STATE_W'(3),
        S_ERR   = STATE_W'(4)
    } state_t;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_SLLV = 3'b011;
    localparam logic [2:0] OP_SRLV = 3'b100;
    localparam logic [2:0] OP_SRAV = 3'b101;
    localparam logic [2:0] OP_LUI  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [1:0] SRC_REGB = 2'b01;
    localparam logic [1:0] SRC_IMM  = 2'b10;
    localparam logic [1:0] AMT_SHAMT = 2'b00;
    localparam logic [1:0] AMT_REGA  = 2'b01;
    localparam logic [1:0] AMT_CONST = 2'b10;

    localparam logic [2:0] CMD_NOP  = 3'b000;
    localparam logic [2:0] CMD_LOAD = 3'b001;
    localparam logic [2:0] CMD_SLL  = 3'b010;
    localparam logic [2:0] CMD_SRL  = 3'b011;
    localparam logic [2:0] CMD_SRA  = 3'b100;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;

    logic [1:0] shift_src_q, shift_src_d;
    logic [1:0] amt_src_q, amt_src_d;
    logic [2:0] shift_cmd_q, shift_cmd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    function automatic logic [1:0] src_of(input logic [2:0] o);
        logic [1:0] s;
        s = 2'b00;
        unique case (o)
            OP_SLL, OP_SRL, OP_SRA,
            OP_SLLV, OP_SRLV, OP_SRAV: s = SRC_REGB;
            OP_LUI:                    s = SRC_IMM;
            default:                   s = 2'b00;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] amt_of(input logic [2:0] o);
        logic [1:0] a;
        a = AMT_SHAMT;
        unique case (o)
            OP_SLL, OP_SRL, OP_SRA:    a = AMT_SHAMT;
            OP_SLLV, OP_SRLV, OP_SRAV: a = AMT_REGA;
            OP_LUI:                    a = AMT_CONST;
            default:                   a = AMT_SHAMT;
        endcase
        return a;
    endfunction

    function automatic logic [2:0] dir_of(input logic [2:0] o);
        logic [2:0] c;
        c = CMD_NOP;
        unique case (o)
            OP_SLL, OP_SLLV, OP_LUI: c = CMD_SLL;
            OP_SRL, OP_SRLV:         c = CMD_SRL;
            OP_SRA, OP_SRAV:         c = CMD_SRA;
            default:                 c = CMD_NOP;
        endcase
        return c;
    endfunction

    // Next state and operation capture; op is latched only on acceptance.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_ILL) begin
                        state_d = S_ERR;
                    end else begin
                        op_d    = op;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        shift_src_d = 2'b00;
        amt_src_d   = 2'b00;
        shift_cmd_d = CMD_NOP;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_LOAD: begin
                shift_src_d = src_of(op_d);
                amt_src_d   = amt_of(op_d);
                shift_cmd_d = CMD_LOAD;
                busy_d      = 1'b1;
            end
            S_SHIFT: begin
                shift_src_d = src_of(op_d);
                amt_src_d   = amt_of(op_d);
                shift_cmd_d = dir_of(op_d);
                busy_d      = 1'b1;
            end
            S_WB: begin
                shift_src_d = src_of(op_d);
                amt_src_d   = amt_of(op_d);
                busy_d      = 1'b1;
                done_d      = 1'b1;
            end
            S_ERR: begin
                busy_d = 1'b1;
                err_d  = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, captured op and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 3'b000;
            shift_src_q <= 2'b00;
            amt_src_q   <= 2'b00;
            shift_cmd_q <= CMD_NOP;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            shift_src_q <= shift_src_d;
            amt_src_q   <= amt_src_d;
            shift_cmd_q <= shift_cmd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign shift_src = shift_src_q;
    assign amt_src   = amt_src_q;
    assign shift_cmd = shift_cmd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_we    = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: directed vector table plus random traffic
// checked against a per-request output-trace model.
module tb_shift_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [1:0] shift_src;
    logic [1:0] amt_src;
    logic [2:0] shift_cmd;
    logic       busy;
    logic       done;
    logic       res_we;
    logic       err;

    shift_ctrl #(
        .LUI_AMT(16),
        .STATE_W(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .shift_src(shift_src),
        .amt_src  (amt_src),
        .shift_cmd(shift_cmd),
        .busy     (busy),
        .done     (done),
        .res_we   (res_we),
        .err      (err)
    );

    always #5 clk = ~clk;

    // {shift_src, amt_src, shift_cmd, busy, done, res_we, err}
    typedef logic [10:0] out_t;

    typedef struct packed {
        logic       r;
        logic       s;
        logic [2:0] o;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    out_t mq[$];
    out_t mexp;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic out_t mk(input logic [1:0] ss, input logic [1:0] as,
                                input logic [2:0] c, input logic b,
                                input logic d, input logic w, input logic e);
        return {ss, as, c, b, d, w, e};
    endfunction

    // One accepted request becomes its full cycle-by-cycle output trace,
    // ending with one idle cycle during which a new start is not taken.
    task automatic gen(input logic [2:0] o);
        int k;
        logic [1:0] ss;
        logic [1:0] as;
        logic [2:0] c;
        k = int'(o);
        if (k == 7) begin
            mq.push_back(mk(2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1));
            mq.push_back('0);
        end else begin
            ss = (k == 6) ? 2'd2 : 2'd1;
            as = (k == 6) ? 2'd2 : ((k >= 3) ? 2'd1 : 2'd0);
            if (k == 6 || k % 3 == 0) c = 3'd2;
            else if (k % 3 == 1)      c = 3'd3;
            else                      c = 3'd4;
            mq.push_back(mk(ss, as, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
            mq.push_back(mk(ss, as, c, 1'b1, 1'b0, 1'b0, 1'b0));
            mq.push_back(mk(ss, as, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
            mq.push_back('0);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            mq.delete();
            mexp = '0;
        end else begin
            if (mq.size() == 0 && start) gen(op);
            if (mq.size() != 0) mexp = mq.pop_front();
            else mexp = '0;
        end
    endtask

    task automatic check(input string nm, input out_t want);
        out_t got;
        got = {shift_src, amt_src, shift_cmd, busy, done, res_we, err};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic [2:0] o,
                         input string nm, input bit has_exp,
                         input out_t want);
        reset = r;
        start = s;
        op    = o;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check({"model_", nm}, mexp);
        if (has_exp) check(nm, want);
    endtask

    task automatic addv(input logic r, input logic s, input logic [2:0] o,
                        input out_t e);
        vec_t v;
        v.r = r;
        v.s = s;
        v.o = o;
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        out_t z;
        z = '0;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        mexp  = '0;

        // reset, then idle
        addv(1, 0, 3'd0, z);
        addv(1, 0, 3'd0, z);
        addv(0, 0, 3'd0, z);
        addv(0, 0, 3'd0, z);
        // SLL
        addv(0, 1, 3'd0, mk(1, 0, 1, 1, 0, 0, 0));
        addv(0, 0, 3'd0, mk(1, 0, 2, 1, 0, 0, 0));
        addv(0, 0, 3'd0, mk(1, 0, 0, 1, 1, 1, 0));
        addv(0, 0, 3'd0, z);
        // illegal
        addv(0, 1, 3'd7, mk(0, 0, 0, 1, 0, 0, 1));
        addv(0, 0, 3'd7, z);
        // SRAV, then LUI held high while busy
        addv(0, 1, 3'd5, mk(1, 1, 1, 1, 0, 0, 0));
        addv(0, 1, 3'd6, mk(1, 1, 4, 1, 0, 0, 0));
        addv(0, 1, 3'd6, mk(1, 1, 0, 1, 1, 1, 0));
        addv(0, 1, 3'd6, z);
        addv(0, 1, 3'd6, mk(2, 2, 1, 1, 0, 0, 0));
        addv(0, 0, 3'd6, mk(2, 2, 2, 1, 0, 0, 0));
        addv(0, 0, 3'd0, mk(2, 2, 0, 1, 1, 1, 0));
        addv(0, 0, 3'd0, z);
        // SRL aborted by reset during SHIFT
        addv(0, 1, 3'd1, mk(1, 0, 1, 1, 0, 0, 0));
        addv(0, 0, 3'd1, mk(1, 0, 3, 1, 0, 0, 0));
        addv(1, 0, 3'd1, z);
        addv(0, 0, 3'd1, z);
        addv(0, 0, 3'd1, z);
        // SLLV with op changed while busy
        addv(0, 1, 3'd3, mk(1, 1, 1, 1, 0, 0, 0));
        addv(0, 1, 3'd1, mk(1, 1, 2, 1, 0, 0, 0));
        addv(0, 0, 3'd1, mk(1, 1, 0, 1, 1, 1, 0));
        addv(0, 0, 3'd1, z);
        // SRA
        addv(0, 1, 3'd2, mk(1, 0, 1, 1, 0, 0, 0));
        addv(0, 0, 3'd2, mk(1, 0, 4, 1, 0, 0, 0));
        addv(0, 0, 3'd2, mk(1, 0, 0, 1, 1, 1, 0));
        addv(0, 0, 3'd2, z);
        // SRLV
        addv(0, 1, 3'd4, mk(1, 1, 1, 1, 0, 0, 0));
        addv(0, 0, 3'd4, mk(1, 1, 3, 1, 0, 0, 0));
        addv(0, 0, 3'd4, mk(1, 1, 0, 1, 1, 1, 0));
        addv(0, 0, 3'd4, z);
        // start during ERR is dropped, next one accepted
        addv(0, 1, 3'd7, mk(0, 0, 0, 1, 0, 0, 1));
        addv(0, 1, 3'd0, z);
        addv(0, 1, 3'd0, mk(1, 0, 1, 1, 0, 0, 0));
        addv(0, 0, 3'd0, mk(1, 0, 2, 1, 0, 0, 0));
        addv(0, 0, 3'd0, mk(1, 0, 0, 1, 1, 1, 0));
        addv(0, 0, 3'd0, z);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].s, vecs[i].o,
                  $sformatf("vec%0d", i), 1'b1, vecs[i].exp);
        end

        for (int i = 0; i < 800; i++) begin
            apply(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), $sformatf("rnd%0d", i),
                  1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
